// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial MSB-first magnitude comparator of two WIDTH-bit unsigned words
//   clk, rst         clock, synchronous active-high reset
//   start            begin a new comparison (taken only in IDLE)
//   bit_valid, A, B  one bit pair per accepted cycle, MSB first
//   busy             high while bits are being accepted
//   done             one-cycle pulse when O1..O3 become valid
//   O1, O2, O3       A>B, A=B, A<B results, held until the next start
//   bit_count        bits accepted in the current word
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bit_valid,
    input  logic                         A,
    input  logic                         B,
    output logic                         busy,
    output logic                         done,
    output logic                         O1,
    output logic                         O2,
    output logic                         O3,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic   decided, gt, lt;
    logic   accept, last, gt_n, lt_n;

    assign accept = (state == RUN) && bit_valid;
    assign last   = accept && (bit_count == CW'(WIDTH - 1));
    // The first differing bit owns the result; later bits only count.
    assign gt_n   = decided ? gt : (A & ~B);
    assign lt_n   = decided ? lt : (~A & B);

    always_comb begin
        state_next = IDLE;
        state_next = (state == IDLE) ? (start ? RUN : IDLE) :
                     (state == RUN)  ? (last ? DONE : RUN)  : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            O1        <= 1'b0;
            O2        <= 1'b0;
            O3        <= 1'b0;
            bit_count <= '0;
            decided   <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next == RUN;
            done  <= state_next == DONE;
            if (state == IDLE && start) begin
                O1        <= 1'b0;
                O2        <= 1'b0;
                O3        <= 1'b0;
                bit_count <= '0;
                decided   <= 1'b0;
                gt        <= 1'b0;
                lt        <= 1'b0;
            end
            if (accept) begin
                bit_count <= bit_count + CW'(1);
                if (!decided && A != B) begin
                    gt      <= A & ~B;
                    lt      <= ~A & B;
                    decided <= 1'b1;
                end
            end
            // Final edge folds the last bit straight into the results.
            if (last) begin
                O1 <= gt_n;
                O2 <= ~(gt_n | lt_n);
                O3 <= lt_n;
            end
        end
    end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: scoreboard bench for serial_comparator at WIDTH=4
module tb_serial_comparator;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       busy, done, O1, O2, O3;
    logic [2:0] bit_count;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    serial_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
        .A(A), .B(B), .busy(busy), .done(done),
        .O1(O1), .O2(O2), .O3(O3), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_done: unexpected done pulse, got O=%b", {O1, O2, O3});
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({O1, O2, O3} !== e) begin
                    bad++;
                    $display("FAIL sb_result: got O=%b want %b", {O1, O2, O3}, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_word;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || bit_count !== 3'd0 || {O1, O2, O3} !== 3'b000) begin
            bad++;
            $display("FAIL start: busy=%b cnt=%0d O=%b want busy=1 cnt=0 O=000", busy, bit_count, {O1, O2, O3});
        end
    endtask

    // Expects RUN on entry; gaps holds 4-bit idle counts before each bit, bit 0 in the low nibble.
    task automatic send_word(input logic [3:0] a, input logic [3:0] b, input logic [15:0] gaps);
        logic [2:0] e;
        e = {a > b, a == b, a < b};
        for (int i = 0; i < W; i++) begin
            for (int g = 0; g < int'(gaps[4*i +: 4]); g++) begin
                bit_valid = 1'b0;
                A = 1'($urandom_range(0, 1));
                B = 1'($urandom_range(0, 1));
                tick();
                total++;
                if (busy !== 1'b1 || bit_count !== 3'(i) || done !== 1'b0) begin
                    bad++;
                    $display("FAIL stall: busy=%b cnt=%0d done=%b want 1/%0d/0", busy, bit_count, done, i);
                end
            end
            bit_valid = 1'b1;
            A = a[W-1-i];
            B = b[W-1-i];
            if (i == W - 1) exp_q.push_back(e);
            tick();
            bit_valid = 1'b0;
            total++;
            if (i < W - 1) begin
                if (busy !== 1'b1 || done !== 1'b0 || bit_count !== 3'(i + 1) || {O1, O2, O3} !== 3'b000) begin
                    bad++;
                    $display("FAIL bit%0d: busy=%b done=%b cnt=%0d O=%b want 1/0/%0d/000", i, busy, done, bit_count, {O1, O2, O3}, i + 1);
                end
            end else if (done !== 1'b1 || busy !== 1'b0 || bit_count !== 3'd4 || {O1, O2, O3} !== e) begin
                bad++;
                $display("FAIL done: done=%b busy=%b cnt=%0d O=%b want 1/0/4/%b", done, busy, bit_count, {O1, O2, O3}, e);
            end
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || {O1, O2, O3} !== e) begin
            bad++;
            $display("FAIL hold: done=%b busy=%b O=%b want 0/0/%b", done, busy, {O1, O2, O3}, e);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        bit_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || {O1, O2, O3} !== 3'b000 || bit_count !== 3'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b O=%b cnt=%0d want all 0", busy, done, {O1, O2, O3}, bit_count);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_greater;
        start_word();
        send_word(4'b1011, 4'b1001, 16'h0000);
    endtask

    task automatic test_less_msb;
        start_word();
        send_word(4'b0111, 4'b1000, 16'h0000);
    endtask

    task automatic test_equal_gaps;
        start_word();
        send_word(4'b0110, 4'b0110, 16'h1300);
    endtask

    task automatic test_reset_mid;
        start_word();
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            A = 1'b1;
            B = 1'b0;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bit_count !== 3'd0 || {O1, O2, O3} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid: busy=%b done=%b cnt=%0d O=%b want all 0", busy, done, bit_count, {O1, O2, O3});
        end
        repeat (3) tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle: done=%b busy=%b want 0/0", done, busy);
        end
        start_word();
        send_word(4'b0001, 4'b0000, 16'h0000);
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        tick();
        send_word(4'b1100, 4'b0011, 16'h0100);
        total++;
        if (busy !== 1'b0 || {O1, O2, O3} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b O=%b want 0/100", busy, {O1, O2, O3});
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || bit_count !== 3'd0 || {O1, O2, O3} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b cnt=%0d O=%b want 1/0/000", busy, bit_count, {O1, O2, O3});
        end
        send_word(4'b0010, 4'b0010, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_greater();
        test_less_msb();
        test_equal_gaps();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_pending: %0d results never reported, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
